// File: rtl/video_frame_reader.sv
// Wishbone burst read master feeding 8-bit pixels into the video FIFO.
// Supports line stride, queued frames and software abort.
module video_frame_reader #(
  parameter int P_WIDTH     = 640,
  parameter int P_HEIGHT    = 480,
  parameter int P_STRIDE    = 640,
  parameter int BURST_WORDS = 4,
  parameter int INT_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] wb_reg_data,
  input  logic [31:0] wb_reg_ctr,
  output logic        busy,
  output logic        interrupt,
  input  logic [31:0] p_wb_DAT_I,
  input  logic        p_wb_ACK_I,
  output logic        p_wb_STB_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_LOCK_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_WE_O,
  output logic [31:0] p_wb_ADR_O,
  input  logic        full,
  output logic        w_e,
  output logic [7:0]  pixel_out
);

  localparam int BB  = 32 * BURST_WORDS;
  localparam int LW  = $clog2(P_HEIGHT + 1);
  localparam int CW  = $clog2(P_WIDTH + 1);
  localparam int WCW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int BCW = $clog2(4 * BURST_WORDS);
  localparam int ICW = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     r_state;
  logic           r_ctr0;
  logic           r_pend;
  logic [31:0]    r_shadow;
  logic [31:0]    r_adr;
  logic [31:0]    r_lbase;
  logic [LW-1:0]  r_line;
  logic [CW-1:0]  r_col;
  logic [WCW-1:0] r_wcnt;
  logic [BCW-1:0] r_bcnt;
  logic [ICW-1:0] r_icnt;
  logic [BB-1:0]  r_buf;

  logic           w_start;
  logic           w_abort;
  logic [31:0]    w_base;
  logic           w_pend;
  logic [31:0]    w_ld;
  logic [BB-1:0]  w_dat;
  logic           w_lastw;
  logic           w_lastb;
  logic           w_eol;
  logic           w_icend;
  logic           w_load;
  logic           w_unused;

  // Control decode: start edge, abort, end-of-packet and load conditions
  always_comb begin
    w_start  = wb_reg_ctr[0] & ~r_ctr0;
    w_abort  = wb_reg_ctr[1] & (r_state != S_IDLE);
    w_base   = {wb_reg_data[31:2], 2'b00};
    w_pend   = r_pend | w_start;
    w_ld     = w_start ? w_base : r_shadow;
    w_dat    = '0;
    w_dat[31:0] = p_wb_DAT_I;
    w_lastw  = r_wcnt == WCW'(BURST_WORDS - 1);
    w_lastb  = r_bcnt == BCW'(4 * BURST_WORDS - 1);
    w_eol    = r_col == CW'(P_WIDTH - 4);
    w_icend  = r_icnt == ICW'(INT_CYCLES - 1);
    w_load   = ~w_abort &
               (((r_state == S_IDLE) & w_start & ~wb_reg_ctr[1]) |
                ((r_state == S_DONE) & w_icend & w_pend));
    w_unused = ^{wb_reg_ctr[31:2], wb_reg_data[1:0]};
  end

  // Frame FSM, address walk, packet buffer and pending-start tracking
  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_ctr0   <= 1'b0;
      r_pend   <= 1'b0;
      r_shadow <= '0;
      r_adr    <= '0;
      r_lbase  <= '0;
      r_line   <= '0;
      r_col    <= '0;
      r_wcnt   <= '0;
      r_bcnt   <= '0;
      r_icnt   <= '0;
      r_buf    <= '0;
    end else begin
      r_ctr0 <= wb_reg_ctr[0];
      if (w_abort) begin
        r_state <= S_IDLE;
        r_pend  <= 1'b0;
        r_wcnt  <= '0;
        r_bcnt  <= '0;
        r_icnt  <= '0;
      end else begin
        if (w_start && r_state != S_IDLE) begin
          r_shadow <= w_base;
          r_pend   <= 1'b1;
        end
        unique case (r_state)
          S_IDLE: ;
          S_READ: begin
            if (p_wb_ACK_I) begin
              r_buf <= (r_buf << 32) | w_dat;
              if (w_eol) begin
                r_col   <= '0;
                r_line  <= r_line + LW'(1);
                r_lbase <= r_lbase + 32'(P_STRIDE);
                r_adr   <= r_lbase + 32'(P_STRIDE);
              end else begin
                r_col <= r_col + CW'(4);
                r_adr <= r_adr + 32'd4;
              end
              if (w_lastw) begin
                r_wcnt  <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_wcnt <= r_wcnt + WCW'(1);
              end
            end
          end
          S_DRAIN: begin
            if (!full) begin
              r_buf <= r_buf << 8;
              if (w_lastb) begin
                r_bcnt  <= '0;
                r_state <= (r_line == LW'(P_HEIGHT)) ? S_DONE : S_READ;
              end else begin
                r_bcnt <= r_bcnt + BCW'(1);
              end
            end
          end
          S_DONE: begin
            if (w_icend) begin
              r_icnt  <= '0;
              r_pend  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_icnt <= r_icnt + ICW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
        if (w_load) begin
          r_state <= S_READ;
          r_adr   <= w_ld;
          r_lbase <= w_ld;
          r_line  <= '0;
          r_col   <= '0;
          r_wcnt  <= '0;
          r_bcnt  <= '0;
        end
      end
    end
  end

  assign busy        = r_state != S_IDLE;
  assign interrupt   = r_state == S_DONE;
  assign p_wb_STB_O  = r_state == S_READ;
  assign p_wb_CYC_O  = r_state == S_READ;
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_SEL_O  = 4'hF;
  assign p_wb_WE_O   = 1'b0;
  assign p_wb_ADR_O  = r_adr;
  assign w_e         = (r_state == S_DRAIN) & ~full;
  assign pixel_out   = (r_state == S_DRAIN) ? r_buf[BB-1 -: 8] : 8'h00;

endmodule
